seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring unsigned divider; the inverse of the combinational Adder.
//   Takes a WIDTH+1-bit dividend (same width as an Adder sum) and a WIDTH-bit divisor.
//   Produces quotient and remainder one bit per clock, using one shared WIDTH+1-bit subtractor.
//   Sits downstream of the sum-of-products datapath (e.g. averaging); valid/ready on both sides.
// PARAMETERS
//   WIDTH  8  divisor/remainder width; dividend and quotient are WIDTH+1 bits
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        dividend/divisor valid
//   in_ready   out  1        block can accept an operand pair
//   dividend   in   WIDTH+1  unsigned dividend
//   divisor    in   WIDTH    unsigned divisor
//   out_valid  out  1        quotient/remainder valid
//   out_ready  in   1        consumer accepts result
//   quotient   out  WIDTH+1  unsigned quotient
//   remainder  out  WIDTH    unsigned remainder
//   busy       out  1        high in CALC or DONE
//   div_zero   out  1        divisor was zero (present only with SEQDIV_ZERO_DET_EN)
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; busy=0;
//     quotient=0; remainder=0; div_zero=0; internal regs=0. In-flight work is discarded.
//   FSM: IDLE -> CALC on in_valid&&in_ready; CALC -> DONE after WIDTH+1 iterations;
//     DONE -> IDLE on out_ready.
//   in_ready = (state==IDLE), combinational from state only. Operands captured at the accepting edge.
//   CALC iteration (one per clk): R = {R[WIDTH-1:0], next dividend MSB};
//     if R >= {1'b0,divisor}: R -= divisor, q bit=1; else q bit=0.
//     R is WIDTH+1 bits internally. A counter runs from WIDTH down to 0.
//   Latency: accept at edge 0 -> out_valid high after edge WIDTH+1 (9 clocks for WIDTH=8).
//   DONE: out_valid=1. quotient/remainder are registered.
//     They hold stable while out_valid && !out_ready.
//     The handshake completes at the edge where out_valid && out_ready.
//   No input is accepted in the handshake cycle; the next accept is possible one cycle later, in IDLE.
//   out_valid is never asserted in the same cycle as in_ready.
//   Result invariant: dividend == quotient*divisor + remainder, with remainder < divisor (divisor != 0).
//   Divisor 0 (base build): the natural restoring result.
//     quotient = all ones; remainder = dividend[WIDTH-1:0]; full WIDTH+1-cycle latency.
//   Input changes while not in IDLE are ignored. in_valid may be held high across results.
// CONFIGURATION
//   SEQDIV_ZERO_DET_EN defined:
//     divisor==0 detected at accept; CALC is skipped; DONE is entered after 1 clk.
//     Result: quotient = all ones; remainder = dividend[WIDTH-1:0]; div_zero=1 while out_valid.
//     div_zero clears on the handshake.
//     Nonzero divisors: behaviour and latency identical to the base build.
//   SEQDIV_ZERO_DET_EN undefined:
//     div_zero port absent; divide-by-zero runs the full iteration count (see BEHAVIOUR).
// TESTING (WIDTH=8)
//   510/7 accepted at edge 0, out_ready=1 -> out_valid at edge 9; q=72, r=6; in_ready high next cycle.
//   0/5 -> q=0, r=0. 511/1 -> q=511, r=0. 254/255 -> q=0, r=254. Each after 9 clocks.
//   300/0 -> q=511, r=44.
//     With SEQDIV_ZERO_DET_EN: out_valid at edge 1, div_zero=1.
//     Without SEQDIV_ZERO_DET_EN: out_valid at edge 9.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> q/r/out_valid stable; in_ready=0; in_valid ignored.
//   Reset: rst_n low at cycle 4 of CALC -> all outputs immediately at reset values.
//     After release, a new 100/3 gives q=33, r=1.
//   Random 1000 pairs with back-to-back in_valid and random out_ready:
//     every result matches the golden / and % values; no operand is dropped or duplicated.

Source files
------------

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result valid-ready bundle for seq_divider.
// The div_zero signal exists only when SEQDIV_ZERO_DET_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
`ifdef SEQDIV_ZERO_DET_EN
    logic             div_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, busy, div_zero
    );
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, busy, div_zero
    );
`else
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, busy
    );
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, busy
    );
`endif
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring unsigned divider, one quotient bit per clock.
// WIDTH+1-bit dividend / WIDTH-bit divisor -> WIDTH+1-bit quotient, WIDTH-bit remainder.
// Optional macro SEQDIV_ZERO_DET_EN: detect divisor==0 at accept, skip the iterations
// and flag the result with div_zero.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [WIDTH:0]   r_work;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_quotient;
    logic [WIDTH-1:0] r_remainder;
`ifdef SEQDIV_ZERO_DET_EN
    logic             r_zero;
`endif

    logic             w_accept;
    logic             w_finish;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH+1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    // Partial remainder R (WIDTH+1 bits) after shifting in the next dividend bit.
    assign w_trial    = {r_rem, r_work[WIDTH]};
    // Single shared subtractor; the extra top bit is the borrow.
    assign w_sub      = {1'b0, w_trial} - {2'b00, r_dvsr};
    assign w_ge       = ~w_sub[WIDTH+1];
    // The remainder never exceeds WIDTH bits once a subtraction is kept.
    assign w_rem_next = w_ge ? WIDTH'(w_sub) : WIDTH'(w_trial);

`ifdef SEQDIV_ZERO_DET_EN
    assign w_finish = (r_state == CALC) && (r_zero || (r_cnt == '0));
`else
    assign w_finish = (r_state == CALC) && (r_cnt == '0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = CALC;
            CALC:    if (w_finish)      w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef SEQDIV_ZERO_DET_EN
            r_zero      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_work <= bus.dividend;
            r_rem  <= '0;
            r_dvsr <= bus.divisor;
            r_cnt  <= CW'(WIDTH);
`ifdef SEQDIV_ZERO_DET_EN
            r_zero <= (bus.divisor == '0);
`endif
        end else if (r_state == CALC) begin
            r_rem  <= w_rem_next;
            r_work <= {r_work[WIDTH-1:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
            if (w_finish) begin
`ifdef SEQDIV_ZERO_DET_EN
                // Zero divisor finishes on the first CALC cycle with the
                // result the full iteration would have produced.
                if (r_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= r_work[WIDTH-1:0];
                end else begin
                    r_quotient  <= {r_work[WIDTH-1:0], w_ge};
                    r_remainder <= w_rem_next;
                end
`else
                r_quotient  <= {r_work[WIDTH-1:0], w_ge};
                r_remainder <= w_rem_next;
`endif
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
`ifdef SEQDIV_ZERO_DET_EN
    assign bus.div_zero  = (r_state == DONE) && r_zero;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider (WIDTH=8)
// against plain / and % arithmetic. Honours SEQDIV_ZERO_DET_EN.
module tb_seq_divider;
    localparam int W = 8;
`ifdef SEQDIV_ZERO_DET_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif
    localparam int NRAND = 1000;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a;
        int b;
    } op_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: unsigned division; divide-by-zero yields all-ones and dividend low bits.
    function automatic void golden(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = (1 << (W + 1)) - 1;
            r = a % (1 << W);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Starts and ends at a negedge; out_ready held high so the result drains immediately.
    task automatic directed(input int a, input int b, input int lat);
        int n;
        int eq;
        int er;
        golden(a, b, eq, er);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 9'(a);
        bus.divisor   = 8'(b);
        chk("dir_in_ready_idle", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dir_latency", n, lat);
        chk("dir_quotient", bus.quotient, eq);
        chk("dir_remainder", bus.remainder, er);
        chk("dir_in_ready_done", bus.in_ready, 0);
        chk("dir_busy_done", bus.busy, 1);
`ifdef SEQDIV_ZERO_DET_EN
        chk("dir_div_zero", bus.div_zero, (b == 0) ? 1 : 0);
`endif
        @(negedge clk);
        chk("dir_out_valid_after", bus.out_valid, 0);
        chk("dir_in_ready_after", bus.in_ready, 1);
    endtask

    initial begin
        op_t sb[$];
        op_t op;
        int  sent;
        int  got;
        int  cyc;
        int  overlap;
        int  eq;
        int  er;
        int  cur_a;
        int  cur_b;
        bit  new_op;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        rst_n = 1'b1;
        @(negedge clk);

        directed(510, 7, W + 1);
        directed(0, 5, W + 1);
        directed(511, 1, W + 1);
        directed(254, 255, W + 1);
        directed(300, 0, ZLAT);

        // Backpressure: result must hold while out_ready is low; in_valid ignored.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.dividend  = 9'd200;
        bus.divisor   = 8'd13;
        @(posedge clk);
        @(negedge clk);
        bus.dividend  = 9'd77;
        bus.divisor   = 8'd5;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_quotient", bus.quotient, 15);
            chk("bp_remainder", bus.remainder, 5);
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_released_valid", bus.out_valid, 0);
        chk("bp_released_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("bp_no_stray_accept", bus.busy, 0);

        // Asynchronous reset in the middle of a calculation.
        bus.in_valid = 1'b1;
        bus.dividend = 9'd250;
        bus.divisor  = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_quotient", bus.quotient, 0);
        chk("arst_remainder", bus.remainder, 0);
`ifdef SEQDIV_ZERO_DET_EN
        chk("arst_div_zero", bus.div_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        directed(100, 3, W + 1);

        // Random stream: in_valid held high, random out_ready, scoreboard in order.
        sent    = 0;
        got     = 0;
        cyc     = 0;
        overlap = 0;
        cur_a   = int'($urandom_range(0, 511));
        cur_b   = int'($urandom_range(0, 255));
        bus.dividend = 9'(cur_a);
        bus.divisor  = 8'(cur_b);
        bus.in_valid = 1'b1;
        while (got < NRAND && cyc < 40000) begin
            new_op = 1'b0;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.in_ready) overlap++;
            if (bus.out_valid && bus.out_ready) begin
                chk("rnd_sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    op = sb.pop_front();
                    golden(op.a, op.b, eq, er);
                    chk("rnd_quotient", bus.quotient, eq);
                    chk("rnd_remainder", bus.remainder, er);
`ifdef SEQDIV_ZERO_DET_EN
                    chk("rnd_div_zero", bus.div_zero, (op.b == 0) ? 1 : 0);
`endif
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{cur_a, cur_b});
                sent++;
                new_op = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (new_op) begin
                if (sent < NRAND) begin
                    cur_a = ($urandom_range(0, 7) == 0) ? 511 : int'($urandom_range(0, 511));
                    cur_b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
                    bus.dividend = 9'(cur_a);
                    bus.divisor  = 8'(cur_b);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        chk("rnd_results", got, NRAND);
        chk("rnd_accepted", sent, NRAND);
        chk("rnd_sb_empty", sb.size(), 0);
        chk("rnd_valid_ready_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
